// File: rtl/sgen_pipe_if.sv
// sgen_pipe_if: valid/ready bundle for the carry-save resolve pipeline
// Ports: in_valid/in_ready/mode/t/c on the accept side, out_valid/out_ready/s/cout/out_mode on the result side.
// slave is the pipeline's view, master is the producer/consumer view.
interface sgen_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_mode;
  modport master (
    output in_valid, mode, t, c, out_ready,
    input  in_ready, out_valid, s, cout, out_mode
  );
  modport slave (
    input  in_valid, mode, t, c, out_ready,
    output in_ready, out_valid, s, cout, out_mode
  );
endinterface

// File: rtl/sgen_pipe.sv
// sgen_pipe: resolves a carry-save pair (t, c) into s, xor (mode 0) or ripple add one segment per stage (mode 1)
// Ports: clk, rst_n (async, active low), io (sgen_pipe_if.slave).
// Optional macro SGEN_CARRY_CNT_EN adds clr_cnt (sync clear) and carry_cnt (saturating count of retired cout=1 results).
// Latency is NSEG = WIDTH/SEG cycles; the whole pipe stalls together whenever the output is held.
module sgen_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SGEN_CARRY_CNT_EN
  input  logic        clr_cnt,
  output logic [15:0] carry_cnt,
`endif
  sgen_pipe_if.slave io
);
  localparam int NSEG = WIDTH / SEG;
  // a_q holds resolved sum bits below the stage boundary and raw t bits above it
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] c_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] c_d [NSEG];
  logic [NSEG-1:0]  v_q, m_q, cy_q, v_d, m_d, cy_d;
  logic [WIDTH-1:0] pa, pc;
  logic             pm, pci;
  logic [SEG:0]     sg;
  logic             adv;
  assign adv          = !v_q[NSEG-1] || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = v_q[NSEG-1];
  assign io.s         = a_q[NSEG-1];
  assign io.cout      = cy_q[NSEG-1];
  assign io.out_mode  = m_q[NSEG-1];
  always_comb begin
    a_d  = '{default: '0};
    c_d  = '{default: '0};
    v_d  = '0;
    m_d  = '0;
    cy_d = '0;
    pa   = '0;
    pc   = '0;
    pm   = 1'b0;
    pci  = 1'b0;
    sg   = '0;
    for (int k = 0; k < NSEG; k++) begin
      pa      = (k == 0) ? io.t : a_q[(k == 0) ? 0 : k - 1];
      pc      = (k == 0) ? io.c : c_q[(k == 0) ? 0 : k - 1];
      pm      = (k == 0) ? io.mode : m_q[(k == 0) ? 0 : k - 1];
      v_d[k]  = (k == 0) ? io.in_valid : v_q[(k == 0) ? 0 : k - 1];
      pci     = (k == 0) ? 1'b0 : cy_q[(k == 0) ? 0 : k - 1];
      sg      = pm ? {1'b0, pa[k*SEG +: SEG]} + {1'b0, pc[k*SEG +: SEG]} + (SEG+1)'(pci)
                   : {1'b0, pa[k*SEG +: SEG] ^ pc[k*SEG +: SEG]};
      a_d[k]  = pa;
      a_d[k][k*SEG +: SEG] = sg[SEG-1:0];
      c_d[k]  = pc;
      m_d[k]  = pm;
      cy_d[k] = sg[SEG];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      m_q  <= '0;
      cy_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= v_d;
      m_q  <= m_d;
      cy_q <= cy_d;
      a_q  <= a_d;
      c_q  <= c_d;
    end
  end
`ifdef SGEN_CARRY_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      carry_cnt <= '0;
    else if (clr_cnt)
      carry_cnt <= '0;
    else if (v_q[NSEG-1] && io.out_ready && cy_q[NSEG-1] && carry_cnt != 16'hFFFF)
      carry_cnt <= carry_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sgen_pipe.sv
// tb_sgen_pipe: table vectors, directed stall/reset sequences and a random stream scored against an arithmetic model
module tb_sgen_pipe;
  localparam int W = 64;
  typedef struct {
    logic         mode;
    logic [W-1:0] t;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;
  typedef struct packed {
    logic         m;
    logic         co;
    logic [W-1:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_n = 0;
  int   tot_n = 0;
  int   ret_cnt = 0;
  exp_t sb[$];
  vec_t tab[7];
  sgen_pipe_if #(.WIDTH(W)) io ();
`ifdef SGEN_CARRY_CNT_EN
  logic        clr_cnt = 1'b0;
  logic [15:0] carry_cnt;
  sgen_pipe #(.WIDTH(W), .SEG(16)) dut (.clk(clk), .rst_n(rst_n), .clr_cnt(clr_cnt), .carry_cnt(carry_cnt), .io(io));
`else
  sgen_pipe #(.WIDTH(W), .SEG(16)) dut (.clk(clk), .rst_n(rst_n), .io(io));
`endif
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout got hang want finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask
  function automatic exp_t model(input logic m, input logic [W-1:0] t, input logic [W-1:0] c);
    logic [W:0] r;
    r = m ? {1'b0, t} + {1'b0, c} : {1'b0, t ^ c};
    return '{m: m, co: r[W], s: r[W-1:0]};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) sb.delete();
    else begin
      if (io.out_valid && io.out_ready) begin
        ret_cnt++;
        if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_s", io.s, e.s);
          chk("sb_cout", io.cout, e.co);
          chk("sb_mode", io.out_mode, e.m);
        end
      end
      if (io.in_valid && io.in_ready) sb.push_back(model(io.mode, io.t, io.c));
    end
  end
  task automatic rnd_word(input logic m);
    logic [W-1:0] c;
    c = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: io.t = ~c;
      1: io.t = ~c + 64'd1;
      default: io.t = {$urandom(), $urandom()};
    endcase
    io.c = c;
    io.mode = m;
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    io.in_valid = 1'b1;
    io.mode = v.mode;
    io.t = v.t;
    io.c = v.c;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 4);
    chk({nm, "_s"}, io.s, v.s);
    chk({nm, "_cout"}, io.cout, v.co);
    chk({nm, "_mode"}, io.out_mode, v.mode);
  endtask
  task automatic drain(input string nm);
    int n;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || io.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, sb.size(), 0);
  endtask
  initial begin
    int r0, sent, guard;
    logic acc, stale;
    logic [W-1:0] hold;
    tab[0] = '{1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_F0F0_0F0F_F0F0, 1'b0};
    tab[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
    tab[2] = '{1'b1, 64'h0000_FFFF_0000_FFFF, 64'h1, 64'h0000_FFFF_0001_0000, 1'b0};
    tab[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1};
    tab[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
    tab[5] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tab[6] = '{1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE, 1'b0};
    io.in_valid = 1'b0;
    io.mode = 1'b0;
    io.t = '0;
    io.c = '0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_s", io.s, 0);
    chk("rst_cout", io.cout, 0);
    chk("rst_out_mode", io.out_mode, 0);
`ifdef SGEN_CARRY_CNT_EN
    chk("rst_carry_cnt", carry_cnt, 0);
`endif
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", io.in_ready, 1);
    for (int i = 0; i < 7; i++) run_vec(tab[i], $sformatf("vec%0d", i));
    drain("drain_vec");
    r0 = ret_cnt;
    for (int i = 0; i < 8; i++) begin
      rnd_word(i[0]);
      io.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_count", ret_cnt - r0, 8);
    chk("stream_done", io.out_valid, 0);
    r0 = ret_cnt;
    for (int i = 0; i < 4; i++) begin
      rnd_word(1'b1);
      io.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rnd_word(1'b0);
    io.out_ready = 1'b0;
    #1;
    hold = io.s;
    chk("stall_out_valid", io.out_valid, 1);
    chk("stall_in_ready", io.in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_s", io.s, hold);
      chk("stall_hold_ready", io.in_ready, 0);
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    drain("drain_stall");
    chk("stall_count", ret_cnt - r0, 5);
    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_word(1'b1);
      io.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flight_out_valid", io.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", io.out_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      stale = stale | io.out_valid;
    end
    chk("no_stale", stale, 0);
`ifdef SGEN_CARRY_CNT_EN
    chk("cnt_after_rst", carry_cnt, 0);
    for (int i = 0; i < 3; i++) run_vec(tab[1], "cnt_vec");
    @(posedge clk); #1;
    chk("cnt_three", carry_cnt, 3);
    run_vec(tab[1], "cnt_clr_vec");
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("cnt_clr_wins", carry_cnt, 0);
`endif
    r0 = ret_cnt;
    sent = 0;
    guard = 0;
    while (sent < 300 && guard < 6000) begin
      if (!io.in_valid && $urandom_range(0, 9) < 7) begin
        rnd_word(1'($urandom_range(0, 1)));
        io.in_valid = 1'b1;
      end
      io.out_ready = $urandom_range(0, 9) < 7;
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        io.in_valid = 1'b0;
      end
      guard++;
    end
    chk("rand_sent", sent, 300);
    drain("drain_rand");
    chk("rand_count", ret_cnt - r0, sent);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
